// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and carry helper for the bit-serial subtractor
package sub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic carry_out(input logic gen, input logic prop, input logic cin);
    return gen | (prop & cin);
  endfunction

endpackage

// File: rtl/full_adder_cp.sv
// rtl/full_adder_cp.sv - one-bit full adder exposing carry propagate/generate terms
module full_adder_cp (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sout,
  output logic prop,
  output logic gen
);

  assign prop = a ^ b;
  assign gen  = a & b;
  assign sout = prop ^ cin;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one bit per clock
// with a start/done handshake; results held until the next completion.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_p;
  logic             fa_g;
  logic             co;

  // a - b is computed as a + ~b + 1; the +1 comes from carry being preset to 1.
  full_adder_cp u_fa (
    .a    (a_sh[0]),
    .b    (~b_sh[0]),
    .cin  (carry),
    .sout (fa_s),
    .prop (fa_p),
    .gen  (fa_g)
  );

  assign co       = carry_out(fa_g, fa_p, carry);
  assign res_next = {fa_s, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b1;
            cnt   <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= co;
          cnt    <= cnt + 1'b1;
          // On the MSB step, carry is the carry into the MSB, so ovf needs no extra register.
          if (cnt == LAST_BIT) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= res_next;
            borrow <= ~co;
            ovf    <= carry ^ co;
            zero   <= (res_next == '0);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench: directed cases plus random pairs vs an arithmetic model
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  bit outstanding = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Track accepted operations from pre-edge input values.
  always @(posedge clk) begin
    if (rst) outstanding = 1'b0;
    else if (start && !busy) outstanding = 1'b1;
  end

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      check("done_after_accept", 32'(outstanding), 32'd1);
      outstanding = 1'b0;
    end
  end

  task automatic ref_model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                           output logic [W-1:0] d, output logic br,
                           output logic ov, output logic z);
    int sa, sb, r;
    d  = W'(int'(ai) - int'(bi));
    br = (ai < bi);
    sa = (ai >= 2 ** (W - 1)) ? int'(ai) - 2 ** W : int'(ai);
    sb = (bi >= 2 ** (W - 1)) ? int'(bi) - 2 ** W : int'(bi);
    r  = sa - sb;
    ov = (r > 2 ** (W - 1) - 1) || (r < -(2 ** (W - 1)));
    z  = (d == '0);
  endtask

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi);
    start = 1'b1;
    a = ai;
    b = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi);
    logic [W-1:0] ed;
    logic eb, eo, ez;
    int n;
    ref_model(ai, bi, ed, eb, eo, ez);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    check({tag, "_latency"}, n, W);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi);
    issue(ai, bi);
    wait_done(tag, ai, bi);
  endtask

  initial begin
    int dc;
    logic [W-1:0] ra, rb;
    logic [W-1:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_flags", {29'd0, borrow, ovf, zero}, 0);

    run_op("t1", 8'h5A, 8'h23);
    check("t1_diff_const", 32'(diff), 32'h37);
    @(posedge clk);
    #1;
    check("t1_done_one_cycle", 32'(done), 0);
    check("t1_hold_diff", 32'(diff), 32'h37);

    run_op("t2a", 8'h10, 8'h20);
    check("t2a_diff_const", 32'(diff), 32'hF0);
    run_op("t2b", 8'h80, 8'h01);
    check("t2b_ovf_const", 32'(ovf), 1);
    run_op("t3a", 8'h33, 8'h33);
    check("t3a_zero_const", 32'(zero), 1);
    run_op("t3b", 8'h00, 8'hFF);
    check("t3b_diff_const", 32'(diff), 32'h01);
    @(posedge clk);
    #1;

    // Start while busy must be ignored.
    dc = done_count;
    issue(8'h5A, 8'h23);
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_busy_hold", 32'(busy), 1);
    check("t4_diff_stable", 32'(diff), 32'h01);
    repeat (12) @(posedge clk);
    #1;
    check("t4_single_done", done_count - dc, 1);
    check("t4_diff", 32'(diff), 32'h37);

    // Back-to-back: second start lands in the done cycle.
    issue(8'h5A, 8'h23);
    wait_done("t5a", 8'h5A, 8'h23);
    issue(8'h02, 8'h05);
    check("t5_b2b_busy", 32'(busy), 1);
    wait_done("t5b", 8'h02, 8'h05);
    check("t5b_diff_const", 32'(diff), 32'hFD);

    // Reset mid-run aborts with no done.
    @(posedge clk);
    #1;
    dc = done_count;
    issue(8'h5A, 8'h23);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    check("t6_diff", 32'(diff), 0);
    check("t6_flags", {29'd0, borrow, ovf, zero}, 0);
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_done", done_count - dc, 0);
    run_op("t6_rerun", 8'h5A, 8'h23);

    for (int i = 0; i < 4000; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      run_op("rnd", ra, rb);
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
